// File: rtl/irq_timer_controller.sv
// Machine-level interrupt source: prescaled 64-bit mtime/mtimecmp timer plus a synchronised
// external line, arbitrated into one request per trap by a request/ack/return FSM.
module irq_timer_controller #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq_async,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        irq_ack,
    input  logic        mret_done,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_valid,
    output logic [1:0]  irq_code,
    output logic        in_handler
);

    localparam int unsigned TIME_W = 64;
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_TMR  = 2'b01;
    localparam logic [1:0] CODE_EXT  = 2'b10;
    localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
    localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
    localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
    localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SVC  = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_presc;
    logic                w_tick;
    logic [TIME_W-1:0]   r_mtime;
    logic [TIME_W-1:0]   r_mtimecmp;
    logic [TIME_W-1:0]   w_mtime_inc;
    logic [TIME_W-1:0]   w_mtime_nxt;
    logic                r_mtip;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                w_ext_edge;
    logic                r_ext_pending;
    logic                w_status_clr;
    logic                w_ack_ext_clr;
    logic                w_elig_ext;
    logic                w_elig_tmr;
    logic                w_src_live;
    logic                w_valid_nxt;
    logic [1:0]          w_code_nxt;
    logic                w_inh_nxt;

    assign w_tick       = (r_presc == CNT_W'(PRESCALE - 1));
    assign w_ext_edge   = r_sync2 & ~r_sync3;
    assign w_status_clr = bus_we & (bus_addr == ADDR_STATUS) & bus_wdata[1];
    assign w_elig_ext   = mstatus_mie & r_ext_pending & mie_meie;
    assign w_elig_tmr   = mstatus_mie & r_mtip & mie_mtie;
    assign w_src_live   = (irq_code == CODE_EXT) ? w_elig_ext : w_elig_tmr;

    // Increment carry still reaches the half that is not being written.
    always_comb begin
        w_mtime_inc = r_mtime + TIME_W'(w_tick);
        w_mtime_nxt = w_mtime_inc;
        if (bus_we) begin
            case (bus_addr)
                ADDR_MTIME_LO: w_mtime_nxt[31:0]  = bus_wdata;
                ADDR_MTIME_HI: w_mtime_nxt[63:32] = bus_wdata;
                default:       w_mtime_nxt        = w_mtime_inc;
            endcase
        end
    end

    // Prescaler, timer registers and registered compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
            r_mtime <= w_mtime_nxt;
            if (bus_we && (bus_addr == ADDR_CMP_LO)) r_mtimecmp[31:0]  <= bus_wdata;
            if (bus_we && (bus_addr == ADDR_CMP_HI)) r_mtimecmp[63:32] <= bus_wdata;
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    // Synchroniser, edge detect and pending latch; a new edge beats any clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_ext_pending <= 1'b0;
        end else begin
            r_sync1 <= ext_irq_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_ext_edge)                        r_ext_pending <= 1'b1;
            else if (w_status_clr | w_ack_ext_clr) r_ext_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            irq_valid  <= 1'b0;
            irq_code   <= CODE_NONE;
            in_handler <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            irq_valid  <= w_valid_nxt;
            irq_code   <= w_code_nxt;
            in_handler <= w_inh_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = 1'b0;
        w_code_nxt    = CODE_NONE;
        w_inh_nxt     = 1'b0;
        w_ack_ext_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_elig_ext) begin
                    w_state_nxt = ST_REQ;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = CODE_EXT;
                end else if (w_elig_tmr) begin
                    w_state_nxt = ST_REQ;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = CODE_TMR;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_nxt   = ST_SVC;
                    w_inh_nxt     = 1'b1;
                    w_ack_ext_clr = (irq_code == CODE_EXT);
                end else if (w_src_live) begin
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = irq_code;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (mret_done) w_state_nxt = ST_IDLE;
                else           w_inh_nxt   = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            ADDR_MTIME_LO: bus_rdata = r_mtime[31:0];
            ADDR_MTIME_HI: bus_rdata = r_mtime[63:32];
            ADDR_CMP_LO:   bus_rdata = r_mtimecmp[31:0];
            ADDR_CMP_HI:   bus_rdata = r_mtimecmp[63:32];
            ADDR_STATUS:   bus_rdata = {30'b0, r_ext_pending, r_mtip};
            default:       bus_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_irq_timer_controller.sv
// Directed bench for irq_timer_controller: timer, external path, arbitration, FSM and reset.
module tb_irq_timer_controller;

    logic        clk;
    logic        reset;
    logic        ext_irq_async;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic        mie_meie;
    logic        irq_ack;
    logic        mret_done;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq_valid;
    logic [1:0]  irq_code;
    logic        in_handler;

    logic        bus_we1;
    logic [2:0]  bus_addr1;
    logic [31:0] bus_wdata1;
    logic [31:0] bus_rdata1;
    logic        irq_valid1;
    logic [1:0]  irq_code1;
    logic        in_handler1;

    int n_tests = 0;
    int n_fail  = 0;

    irq_timer_controller #(.PRESCALE(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .ext_irq_async(ext_irq_async),
        .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
        .irq_ack(irq_ack), .mret_done(mret_done),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .irq_valid(irq_valid), .irq_code(irq_code), .in_handler(in_handler)
    );

    irq_timer_controller #(.PRESCALE(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .ext_irq_async(ext_irq_async),
        .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
        .irq_ack(irq_ack), .mret_done(mret_done),
        .bus_we(bus_we1), .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata1),
        .irq_valid(irq_valid1), .irq_code(irq_code1), .in_handler(in_handler1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(tag, 64'(bus_rdata), 64'(exp));
    endtask

    task automatic chk_rd1(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus_addr1 = a;
        #1;
        chk(tag, 64'(bus_rdata1), 64'(exp));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic v, input logic [1:0] c, input logic h);
        chk({tag, "_valid"}, 64'(irq_valid), 64'(v));
        chk({tag, "_code"}, 64'(irq_code), 64'(c));
        chk({tag, "_inh"}, 64'(in_handler), 64'(h));
    endtask

    initial begin
        reset = 1'b1; ext_irq_async = 1'b0; mstatus_mie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0;
        irq_ack = 1'b0; mret_done = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 32'h0;
        bus_we1 = 1'b0; bus_addr1 = 3'd0; bus_wdata1 = 32'h0;
        tick(2);

        // Reset values
        chk_irq("rst", 1'b0, 2'b00, 1'b0);
        chk("rst_dut1_valid", 64'({irq_valid1, irq_code1, in_handler1}), 64'h0);
        chk_rd("rst_mtime_lo", 3'd0, 32'h0);
        chk_rd("rst_mtime_hi", 3'd1, 32'h0);
        chk_rd("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        chk_rd("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        chk_rd("rst_status", 3'd4, 32'h0);
        reset = 1'b0; mstatus_mie = 1'b1; mie_mtie = 1'b1;

        // Timer: edges counted from reset release; mtime = 3 after edge 12
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h3);
        tick(9);
        chk_rd("tmr_mtime_e11", 3'd0, 32'd2);
        chk_rd("tmr_status_e11", 3'd4, 32'h0);
        tick();
        chk_rd("tmr_mtime_e12", 3'd0, 32'd3);
        chk_rd("tmr_status_e12", 3'd4, 32'h0);
        chk_irq("tmr_e12", 1'b0, 2'b00, 1'b0);
        tick();
        chk_rd("tmr_status_e13", 3'd4, 32'h1);
        chk_irq("tmr_e13", 1'b0, 2'b00, 1'b0);
        tick();
        chk_irq("tmr_req", 1'b1, 2'b01, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_irq("tmr_svc", 1'b0, 2'b00, 1'b1);
        mret_done = 1'b1; mie_mtie = 1'b0;
        tick();
        mret_done = 1'b0;
        chk_irq("tmr_ret", 1'b0, 2'b00, 1'b0);
        tick();
        chk_irq("tmr_idle", 1'b0, 2'b00, 1'b0);
        wr(3'd3, 32'hFFFF_FFFF);
        tick();
        chk_rd("tmr_mtip_clr", 3'd4, 32'h0);

        // External: sampled at edge N, pending after N+2, request after N+3
        mie_meie = 1'b1; ext_irq_async = 1'b1;
        tick();
        chk_irq("ext_n0", 1'b0, 2'b00, 1'b0);
        tick();
        chk_rd("ext_status_n1", 3'd4, 32'h0);
        tick();
        chk_rd("ext_status_n2", 3'd4, 32'h2);
        chk_irq("ext_n2", 1'b0, 2'b00, 1'b0);
        tick();
        chk_irq("ext_req", 1'b1, 2'b10, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_irq("ext_svc", 1'b0, 2'b00, 1'b1);
        chk_rd("ext_status_ack", 3'd4, 32'h0);
        tick(2);
        chk_rd("ext_held_one_edge", 3'd4, 32'h0);
        mret_done = 1'b1;
        tick();
        mret_done = 1'b0;
        chk_irq("ext_ret", 1'b0, 2'b00, 1'b0);
        ext_irq_async = 1'b0;
        tick(3);
        chk_irq("ext_idle", 1'b0, 2'b00, 1'b0);

        // Both eligible at once: external wins, timer follows after mret
        mstatus_mie = 1'b0; mie_mtie = 1'b1;
        wr(3'd3, 32'h0);
        ext_irq_async = 1'b1;
        tick(4);
        chk_rd("both_status", 3'd4, 32'h3);
        mstatus_mie = 1'b1;
        tick();
        chk_irq("both_req_ext", 1'b1, 2'b10, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_rd("both_status_svc", 3'd4, 32'h1);
        mret_done = 1'b1;
        tick();
        mret_done = 1'b0;
        chk_irq("both_ret", 1'b0, 2'b00, 1'b0);
        tick();
        chk_irq("both_req_tmr", 1'b1, 2'b01, 1'b0);

        // Enable dropped while requesting: withdraw, source stays pending
        mstatus_mie = 1'b0;
        tick();
        chk_irq("drop", 1'b0, 2'b00, 1'b0);
        chk_rd("drop_status", 3'd4, 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_irq("ack_in_idle", 1'b0, 2'b00, 1'b0);
        mie_mtie = 1'b0;
        wr(3'd3, 32'hFFFF_FFFF);
        ext_irq_async = 1'b0;
        tick(3);
        chk_rd("drop_status_clr", 3'd4, 32'h0);

        // New edge during service waits for mret
        mstatus_mie = 1'b1; ext_irq_async = 1'b1;
        tick(4);
        chk_irq("svc_req1", 1'b1, 2'b10, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0; ext_irq_async = 1'b0;
        tick(3);
        ext_irq_async = 1'b1;
        tick(4);
        chk_irq("svc_hold", 1'b0, 2'b00, 1'b1);
        chk_rd("svc_status_pend", 3'd4, 32'h2);
        mret_done = 1'b1;
        tick();
        mret_done = 1'b0;
        chk_irq("svc_ret", 1'b0, 2'b00, 1'b0);
        tick();
        chk_irq("svc_rereq", 1'b1, 2'b10, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0; ext_irq_async = 1'b0;
        chk_rd("svc_status_ack", 3'd4, 32'h0);
        tick(3);

        // Status clear coinciding with the edge: set wins; a later clear works
        ext_irq_async = 1'b1;
        tick(2);
        wr(3'd4, 32'h2);
        chk_rd("clr_vs_edge", 3'd4, 32'h2);
        chk_irq("clr_vs_edge", 1'b0, 2'b00, 1'b1);
        wr(3'd4, 32'h2);
        chk_rd("clr_status", 3'd4, 32'h0);
        mret_done = 1'b1;
        tick();
        mret_done = 1'b0;
        tick();
        chk_irq("clr_idle", 1'b0, 2'b00, 1'b0);
        chk_rd("addr5_read0", 3'd5, 32'h0);

        // Reset while requesting
        mie_mtie = 1'b1;
        wr(3'd3, 32'h0);
        tick(2);
        chk_irq("pre_rst_req", 1'b1, 2'b01, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0; mie_mtie = 1'b0; mstatus_mie = 1'b0; ext_irq_async = 1'b0;
        chk_irq("mid_rst", 1'b0, 2'b00, 1'b0);
        chk_rd("mid_rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        chk_rd("mid_rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        chk_rd("mid_rst_mtime", 3'd0, 32'h0);
        chk_rd("mid_rst_status", 3'd4, 32'h0);

        // PRESCALE=1 instance: 64-bit wrap
        tick(3);
        bus_we1 = 1'b1; bus_addr1 = 3'd1; bus_wdata1 = 32'hFFFF_FFFF;
        tick();
        bus_addr1 = 3'd0;
        tick();
        bus_we1 = 1'b0;
        chk_rd1("wrap_pre_lo", 3'd0, 32'hFFFF_FFFF);
        chk_rd1("wrap_pre_hi", 3'd1, 32'hFFFF_FFFF);
        tick();
        chk_rd1("wrap_lo", 3'd0, 32'h0);
        chk_rd1("wrap_hi", 3'd1, 32'h0);
        tick();
        chk_rd1("wrap_next", 3'd0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
